tcdm_bank_resp: RTL and testbench

// Bank-side responder for one output port of the butterfly TCDM network.

---
 rtl/tcdm_bank_pkg.sv | 37 +++
 rtl/tcdm_be_merge.sv | 17 +
 rtl/tcdm_bank_resp.sv | 127 ++++++++++++
 tb/tb_tcdm_bank_resp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_bank_pkg.sv
// Shared definitions for the TCDM bank responder: request layout, FSM states
// and the request unpacking helper.
package tcdm_bank_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8;
  localparam int unsigned ADDR_WIDTH     = 10;
  localparam int unsigned REQ_DATA_WIDTH = 1 + BE_WIDTH + ADDR_WIDTH + DATA_WIDTH;

  // Packed request is {wen, be, addr, wdata} with wen in the MSB
  localparam int unsigned WDATA_LSB = 0;
  localparam int unsigned ADDR_LSB  = WDATA_LSB + DATA_WIDTH;
  localparam int unsigned BE_LSB    = ADDR_LSB + ADDR_WIDTH;
  localparam int unsigned WEN_BIT   = BE_LSB + BE_WIDTH;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  typedef struct packed {
    logic                  wen;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  function automatic req_t unpack_req(input logic [REQ_DATA_WIDTH-1:0] data);
    req_t r;
    r.wen   = data[WEN_BIT];
    r.be    = data[BE_LSB +: BE_WIDTH];
    r.addr  = data[ADDR_LSB +: ADDR_WIDTH];
    r.wdata = data[WDATA_LSB +: DATA_WIDTH];
    return r;
  endfunction

endpackage

// File: rtl/tcdm_be_merge.sv
// Combinational byte merge: each byte lane takes new_word when its enable is
// set, otherwise keeps old_word.
module tcdm_be_merge #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8
) (
  input  logic [DataWidth-1:0] old_word,
  input  logic [DataWidth-1:0] new_word,
  input  logic [BeWidth-1:0]   be,
  output logic [DataWidth-1:0] word
);

  for (genvar i = 0; i < BeWidth; i++) begin : g_byte
    assign word[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/tcdm_bank_resp.sv
// Bank-side responder for one butterfly TCDM output port: fixed 1-cycle
// response latency, byte-enable writes emulated by read-modify-write.
module tcdm_bank_resp
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [REQ_DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic [CntWidth-1:0]       rmw_cnt_o
);

  state_e                state_q, state_d;
  req_t                  req;
  logic                  full_be, is_read, is_full, is_part;
  logic                  grant;
  logic                  rd_sel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged;
  logic [CntWidth-1:0]   cnt_q;

  // Request class decode; a write with be=0 is granted but never touches the SRAM
  assign req     = unpack_req(data_i);
  assign full_be = (req.be == {BE_WIDTH{1'b1}});
  assign is_read = !req.wen;
  assign is_full = req.wen && full_be;
  assign is_part = req.wen && !full_be && (req.be != '0);

  assign grant = (state_q == IDLE) && req_i && !rst_i;

  tcdm_be_merge #(
    .DataWidth (DATA_WIDTH),
    .BeWidth   (BE_WIDTH)
  ) i_be_merge (
    .old_word (mem_rdata_i),
    .new_word (wdata_q),
    .be       (be_q),
    .word     (merged)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant && is_part) state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and SRAM port; a reset arriving in RMW_WR drops the pending write
  always_comb begin
    gnt_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        gnt_o = grant;
        if (grant && (is_read || is_part)) begin
          mem_req_o  = 1'b1;
          mem_addr_o = req.addr;
        end else if (grant && is_full) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = req.addr;
          mem_wdata_o = req.wdata;
        end
      end
      RMW_WR: begin
        if (!rst_i) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = addr_q;
          mem_wdata_o = merged;
        end
      end
      default: ;
    endcase
  end

  // Partial-write capture, response select and saturating RMW counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_sel_q <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      rd_sel_q <= grant && is_read;
      if (grant && is_part) begin
        addr_q  <= req.addr;
        be_q    <= req.be;
        wdata_q <= req.wdata;
      end
      if ((state_q == RMW_WR) && (cnt_q != {CntWidth{1'b1}})) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

  assign rdata_o   = rd_sel_q ? mem_rdata_i : '0;
  assign rmw_cnt_o = cnt_q;

endmodule

// File: tb/tb_tcdm_bank_resp.sv
// Self-checking bench for tcdm_bank_resp: directed scenarios plus a randomized
// run against a transaction-level memory model.
module tb_tcdm_bank_resp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned BW = 4;
  localparam int unsigned RW = 1 + BW + AW + DW;
  localparam int unsigned CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic          gnt_o;
  logic [RW-1:0] data_i = '0;
  logic [DW-1:0] rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic [CW-1:0] rmw_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  tcdm_bank_resp #(.CntWidth(CW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .data_i      (data_i),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .rmw_cnt_o   (rmw_cnt_o)
  );

  // Word-write-only SRAM with one cycle of read latency
  logic [DW-1:0] sram [1024];
  logic [DW-1:0] sram_rdata;
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
      else          sram_rdata <= sram[mem_addr_o];
    end
  end
  assign mem_rdata_i = sram_rdata;

  function automatic logic [RW-1:0] pack(input logic wen, input logic [BW-1:0] be,
                                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    return {wen, be, addr, wd};
  endfunction

  function automatic logic [DW-1:0] merge_ref(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                              input logic [BW-1:0] be);
    logic [DW-1:0] r;
    for (int b = 0; b < int'(BW); b++) r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  // One cycle: drive after the falling edge, then let combinational outputs settle
  task automatic cyc(input logic rst, input logic req, input logic wen, input logic [BW-1:0] be,
                     input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    @(negedge clk_i);
    rst_i  = rst;
    req_i  = req;
    data_i = pack(wen, be, addr, wd);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
      checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b exp 0", gnt_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req_o); end
      checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rdata_o); end
      checks++; if (rmw_cnt_o !== 4'h0) begin errors++; $display("FAIL reset_cnt: got %h exp 0", rmw_cnt_o); end
    end
  endtask

  task automatic test_full_wr_rd();
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF);
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL full_wr_gnt: got %b exp 1", gnt_o); end
    checks++; if (mem_we_o !== 1'b1) begin errors++; $display("FAIL full_wr_we: got %b exp 1", mem_we_o); end
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL full_rd_gnt: got %b exp 1", gnt_o); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL full_wr_rdata: got %h exp 0", rdata_o); end
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL full_rd_rdata: got %h exp deadbeef", rdata_o); end
  endtask

  task automatic test_part_wr();
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 10'h020, 32'h11223344);
    cyc(1'b0, 1'b1, 1'b1, 4'b0101, 10'h020, 32'hAABBCCDD);
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL part_gnt: got %b exp 1", gnt_o); end
    checks++; if ({mem_req_o, mem_we_o} !== 2'b10) begin errors++; $display("FAIL part_rd_issue: got req/we %b%b exp 10", mem_req_o, mem_we_o); end
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 10'h030, 32'h0);
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL part_bubble_gnt: got %b exp 0", gnt_o); end
    checks++; if ({mem_req_o, mem_we_o} !== 2'b11) begin errors++; $display("FAIL part_wr_issue: got req/we %b%b exp 11", mem_req_o, mem_we_o); end
    checks++; if (mem_addr_o !== 10'h020) begin errors++; $display("FAIL part_wr_addr: got %h exp 020", mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'h11BB33DD) begin errors++; $display("FAIL part_wr_wdata: got %h exp 11bb33dd", mem_wdata_o); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL part_rdata: got %h exp 0", rdata_o); end
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 10'h030, 32'h0);
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL part_next_gnt: got %b exp 1", gnt_o); end
    checks++; if (rmw_cnt_o !== 4'h1) begin errors++; $display("FAIL part_cnt: got %h exp 1", rmw_cnt_o); end
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    checks++; if (sram[10'h020] !== 32'h11BB33DD) begin errors++; $display("FAIL part_mem: got %h exp 11bb33dd", sram[10'h020]); end
  endtask

  task automatic test_rmw_hazard();
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 10'h020, 32'h11223344);
    cyc(1'b0, 1'b1, 1'b1, 4'b0101, 10'h020, 32'hAABBCCDD);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL hazard_gnt1: got %b exp 0", gnt_o); end
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL hazard_gnt2: got %b exp 1", gnt_o); end
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    checks++; if (rdata_o !== 32'h11BB33DD) begin errors++; $display("FAIL hazard_rdata: got %h exp 11bb33dd", rdata_o); end
  endtask

  task automatic test_reset_mid_rmw();
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 10'h020, 32'h11223344);
    cyc(1'b0, 1'b1, 1'b1, 4'b0101, 10'h020, 32'hAABBCCDD);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL midrst_mem_req: got %b exp 0", mem_req_o); end
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL midrst_idle_gnt: got %b exp 1", gnt_o); end
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    checks++; if (rdata_o !== 32'h11223344) begin errors++; $display("FAIL midrst_rdata: got %h exp 11223344", rdata_o); end
    checks++; if (sram[10'h020] !== 32'h11223344) begin errors++; $display("FAIL midrst_mem: got %h exp 11223344", sram[10'h020]); end
    checks++; if (rmw_cnt_o !== 4'h0) begin errors++; $display("FAIL midrst_cnt: got %h exp 0", rmw_cnt_o); end
  endtask

  task automatic test_cnt_saturation();
    int exp_c;
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 4'($urandom_range(1, 14)), 10'h100 + 10'($urandom_range(0, 15)), $urandom);
      exp_c = (i < 15) ? i : 15;
      checks++; if (rmw_cnt_o !== 4'(exp_c)) begin errors++; $display("FAIL sat_cnt_%0d: got %h exp %h", i, rmw_cnt_o, exp_c); end
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    checks++; if (rmw_cnt_o !== 4'hF) begin errors++; $display("FAIL sat_cnt_final: got %h exp f", rmw_cnt_o); end
  endtask

  task automatic test_random();
    logic [DW-1:0] gold [16];
    logic          bubble = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    int unsigned   exp_cnt = 0;
    logic          req, wen, exp_gnt;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    int unsigned   idx, cls;
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    for (int n = 0; n < 416; n++) begin
      wd = $urandom;
      if (n < 16) begin
        req = 1'b1; wen = 1'b1; be = 4'hF; idx = n;
      end else begin
        req = ($urandom_range(0, 3) != 0);
        cls = $urandom_range(0, 3);
        idx = $urandom_range(0, 15);
        case (cls)
          0:       begin wen = 1'b0; be = 4'($urandom); end
          1:       begin wen = 1'b1; be = 4'hF; end
          2:       begin wen = 1'b1; be = 4'($urandom_range(1, 14)); end
          default: begin wen = 1'b1; be = 4'h0; end
        endcase
      end
      cyc(1'b0, req, wen, be, 10'h040 + 10'(idx), wd);
      exp_gnt = req && !bubble;
      checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rand_gnt@%0d: got %b exp %b", n, gnt_o, exp_gnt); end
      checks++; if (rdata_o !== exp_rdata) begin errors++; $display("FAIL rand_rdata@%0d: got %h exp %h", n, rdata_o, exp_rdata); end
      checks++; if (rmw_cnt_o !== 4'(exp_cnt)) begin errors++; $display("FAIL rand_cnt@%0d: got %h exp %h", n, rmw_cnt_o, exp_cnt); end
      if (bubble) exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      bubble    = exp_gnt && wen && (be != 4'hF) && (be != 4'h0);
      exp_rdata = (exp_gnt && !wen) ? gold[idx] : '0;
      if (exp_gnt && wen) gold[idx] = merge_ref(gold[idx], wd, be);
    end
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (sram[10'h040 + 10'(i)] !== gold[i]) begin
        errors++; $display("FAIL rand_mem[%0d]: got %h exp %h", i, sram[10'h040 + 10'(i)], gold[i]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_wr_rd();
    test_part_wr();
    test_rmw_hazard();
    test_reset_mid_rmw();
    test_cnt_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
